interrupt_request_controller: RTL
=================================

INTERRUPT_REQUEST_CONTROLLER -- requirements
Module: interrupt_request_controller

Interface
REQ-001 SHALL have parameter MASK_RESET, default 4'b1111, giving the reset value of the mask register.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port irqIn  input  4  interrupt sources; bit 0 is driven by the hardware-interrupt handler output, bits 1-3 by timer/serial/spare; level inputs, sampled every clock.
REQ-005 SHALL have port globalEnable  input  1  master interrupt enable (status IE bit).
REQ-006 SHALL have port maskWrite  input  1  load strobe for the mask register.
REQ-007 SHALL have port maskIn  input  4  new mask value; bit i=1 enables source i.
REQ-008 SHALL have port interruptAck  input  1  pipeline accepted the current request.
REQ-009 SHALL have port eret  input  1  handler finished; return from exception.
REQ-010 SHALL have port interruptRequest  output  1  request to the pipeline.
REQ-011 SHALL have port interruptCause  output  2  index of the requested source; valid while interruptRequest=1.
REQ-012 SHALL have port inService  output  1  handler is running.
REQ-013 SHALL have port pendingOut  output  4  current pending bits, for cause-register readback.
REQ-014 SHALL have port maskOut  output  4  current mask register.

Function
REQ-015 SHALL keep a per-source previous-sample register and detect a rising edge as irqIn[i]=1 with previous sample 0.
REQ-016 SHALL set pending[i] on the clock edge at which a rising edge of irqIn[i] is sampled, whether or not the source is masked.
REQ-017 SHALL keep pending[i] set until it is cleared by an accepted acknowledge for source i; masking SHALL NOT clear it.
REQ-018 SHALL leave pending[i]=1 when a new rising edge on source i coincides with the acknowledge of source i, so the new event is kept.
REQ-019 SHALL load the mask register from maskIn on a clock edge with maskWrite=1; the new mask SHALL take effect for arbitration on the following cycle.
REQ-020 SHALL implement the FSM states IDLE, REQUEST and SERVICE.
REQ-021 In IDLE, when globalEnable=1 and (pending & mask) is non-zero, the FSM SHALL move to REQUEST and latch interruptCause as the lowest set index of (pending & mask), where bit 0 has the highest priority.
REQ-022 In REQUEST, the block SHALL drive interruptRequest=1 and SHALL hold interruptCause stable.
REQ-023 In REQUEST with interruptAck=1, the FSM SHALL move to SERVICE and clear pending[interruptCause] on that edge.
REQ-024 In REQUEST with interruptAck=0 and globalEnable=0, the FSM SHALL withdraw to IDLE with the pending bit untouched; interruptAck SHALL take priority over withdrawal.
REQ-025 In SERVICE, the block SHALL drive inService=1 and interruptRequest=0; the FSM SHALL return to IDLE on eret=1, and no nesting is allowed.
REQ-026 SHALL ignore interruptAck in IDLE and SERVICE, and SHALL ignore eret in IDLE and REQUEST.
REQ-027 SHALL meet a latency of 2 clocks: with the FSM in IDLE, globalEnable=1 and the source unmasked, a rising edge sampled at edge k SHALL give pending at edge k, and interruptRequest=1 with the correct cause after edge k+1.
REQ-028 SHALL re-arbitrate on return to IDLE, so that remaining pending and unmasked sources are requested 1 cycle after eret.
REQ-029 SHALL drive all outputs directly from registers, with no combinational path from input to output.

Reset
REQ-030 When reset=1 at a clock edge, the block SHALL set state=IDLE, pending=0, previous samples=0, mask=MASK_RESET and interruptCause=0.
REQ-031 During reset the outputs SHALL be interruptRequest=0, inService=0, pendingOut=0 and maskOut=MASK_RESET.
REQ-032 Reset SHALL take priority over all other inputs, and reset asserted in REQUEST or SERVICE SHALL abort the operation with no pending bit preserved.
REQ-033 If an irqIn bit is high when reset is released, it SHALL be seen as a rising edge on the first cycle after reset.

Verification
REQ-034 The bench SHALL cover single source: reset, globalEnable=1, irqIn=0001 for 1 cycle -> interruptRequest=1 and cause=0 two cycles later; ack -> inService=1 and pendingOut=0000; eret -> IDLE.
REQ-035 The bench SHALL cover priority: irqIn=1010 pulsed together -> cause=1; after ack and eret -> cause=3 is requested 1 cycle after eret.
REQ-036 The bench SHALL cover masking: maskIn=1110 written, then irqIn bit 0 pulsed -> pendingOut=0001 and no request; write mask 1111 -> request with cause=0.
REQ-037 The bench SHALL cover withdrawal: in REQUEST drop globalEnable with ack=0 -> IDLE and pending kept; in a second run, drop globalEnable with ack=1 on the same edge -> SERVICE.
REQ-038 The bench SHALL cover simultaneous events: a new rising edge on source 2 on the same edge as the ack of cause=2 -> pendingOut[2]=1 after the edge, and source 2 is requested again after eret.
REQ-039 The bench SHALL cover reset mid-service: assert reset in SERVICE with pending=0110 -> all outputs at their reset values; irqIn held high through reset -> request appears 2 cycles after release.

Source files
------------

// File: rtl/interrupt_request_controller.sv
// Purpose: latches rising edges of four interrupt sources, masks and arbitrates them, and runs a request/service handshake with the pipeline.
// Latency: an edge sampled at clock k is pending after k; interruptRequest and interruptCause are valid after k+1 (IDLE, enabled, unmasked).
// Backpressure: a request is held until interruptAck, or withdrawn when globalEnable drops; no new request is made until eret ends service.
module interrupt_request_controller #(
  parameter logic [3:0] MASK_RESET = 4'b1111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] irqIn,
  input  logic       globalEnable,
  input  logic       maskWrite,
  input  logic [3:0] maskIn,
  input  logic       interruptAck,
  input  logic       eret,
  output logic       interruptRequest,
  output logic [1:0] interruptCause,
  output logic       inService,
  output logic [3:0] pendingOut,
  output logic [3:0] maskOut
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Registered state
  state_t     state_q,   state_d;
  logic [3:0] prev_q,    prev_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q,    mask_d;
  logic [1:0] cause_q,   cause_d;
  logic       req_q,     req_d;
  logic       svc_q,     svc_d;

  // Combinational helpers
  logic [3:0] rise;
  logic [3:0] eligible;
  logic       any_eligible;
  logic [1:0] arb_idx;
  logic       ack_accept;
  logic [3:0] ack_clear;

  // Edge detection against the previous sample of each source
  always_comb begin
    rise   = irqIn & ~prev_q;
    prev_d = irqIn;
  end

  // Fixed-priority arbitration over pending and unmasked sources; bit 0 wins
  always_comb begin
    eligible     = pending_q & mask_q;
    any_eligible = |eligible;
    arb_idx      = 2'd0;
    casez (eligible)
      4'b???1: arb_idx = 2'd0;
      4'b??10: arb_idx = 2'd1;
      4'b?100: arb_idx = 2'd2;
      4'b1000: arb_idx = 2'd3;
      default: arb_idx = 2'd0;
    endcase
  end

  // Acknowledge is only meaningful while a request is outstanding
  always_comb begin
    ack_accept = (state_q == REQUEST) && interruptAck;
    ack_clear  = 4'b0000;
    if (ack_accept) begin
      ack_clear[cause_q] = 1'b1;
    end
  end

  // Pending bits: a new edge wins over a same-cycle acknowledge so it is not lost;
  // masking never clears a pending bit
  always_comb begin
    pending_d = (pending_q & ~ack_clear) | rise;
  end

  // Mask register; the new value steers arbitration from the next cycle on
  always_comb begin
    mask_d = mask_q;
    if (maskWrite) begin
      mask_d = maskIn;
    end
  end

  // Request/service state machine; acknowledge beats withdrawal in REQUEST
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (globalEnable && any_eligible) begin
          state_d = REQUEST;
          cause_d = arb_idx;
        end
      end
      REQUEST: begin
        if (interruptAck) begin
          state_d = SERVICE;
        end else if (!globalEnable) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eret) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_d = (state_d == REQUEST);
    svc_d = (state_d == SERVICE);
  end

  // State update with synchronous reset; reset aborts any request or service
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_q    <= 4'b0000;
      pending_q <= 4'b0000;
      mask_q    <= MASK_RESET;
      cause_q   <= 2'd0;
      req_q     <= 1'b0;
      svc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
      req_q     <= req_d;
      svc_q     <= svc_d;
    end
  end

  // Every output comes straight from a flop
  assign interruptRequest = req_q;
  assign interruptCause   = cause_q;
  assign inService        = svc_q;
  assign pendingOut       = pending_q;
  assign maskOut          = mask_q;

endmodule
